fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the immediate generator and decoder.
- Holds the 64-bit PC and issues word requests to instruction memory over a valid/ready request with a separate response strobe.
- Latches the returned 32-bit instruction and presents it with its PC.
- Splits the instruction into the OpCode / InstructionP1 / InstructionP2 fields that the immediate generator consumes.
- Accepts branch/jump redirects from execute and flags misaligned targets.

---
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch stage. Holds the 64-bit PC, issues word
//             requests to instruction memory (valid/ready request, separate
//             response strobe), latches the returned instruction with its PC,
//             slices the fields used by the immediate generator, and accepts
//             redirects from execute, trapping misaligned targets.
//  Ports    :
//    clk, rst                 clock (rising edge), async active-high reset
//    imem_req_valid/ready     request handshake, imem_addr = PC
//    imem_rsp_valid/data      one response per accepted request, in order
//    stall                    downstream cannot consume this cycle
//    redirect_valid/target    load a new PC
//    if_valid/if_pc/if_instr  held instruction and its PC
//    OpCode/InstructionP1/P2  combinational slices of if_instr
//    fetch_fault              sticky misaligned-redirect flag
//    instr_count              instructions consumed downstream
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [63:0]      imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [63:0]      redirect_target,
    output logic             if_valid,
    output logic [63:0]      if_pc,
    output logic [31:0]      if_instr,
    output logic [4:0]       OpCode,
    output logic [11:0]      InstructionP1,
    output logic [4:0]       InstructionP2,
    output logic             fetch_fault,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t      state;
    logic [63:0] pc;

    // Request is a pure function of state so it is visible the moment reset
    // is released; the address is the PC, which only changes on a redirect
    // while in REQ (the request is then withdrawn/retargeted together).
    assign imem_req_valid = (state == S_REQ);
    assign imem_addr      = pc;

    assign OpCode        = if_instr[6:2];
    assign InstructionP1 = if_instr[31:20];
    assign InstructionP2 = if_instr[11:7];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            if_valid    <= 1'b0;
            if_pc       <= 64'h0;
            if_instr    <= 32'h0;
            fetch_fault <= 1'b0;
            instr_count <= '0;
        end else if (redirect_valid && state != S_FAULT) begin
            // Redirect wins over consume, response and handshake; a held
            // instruction is dropped without being counted.
            if_valid <= 1'b0;
            if (redirect_target[1:0] != 2'b00) begin
                fetch_fault <= 1'b1;
                state       <= S_FAULT;
            end else begin
                pc <= redirect_target;
                // A request already accepted by memory still owes a response
                // that must be swallowed before fetching from the new PC.
                case (state)
                    S_REQ:   state <= imem_req_ready ? S_DRAIN : S_REQ;
                    S_WAIT:  state <= imem_rsp_valid ? S_REQ : S_DRAIN;
                    S_DRAIN: state <= imem_rsp_valid ? S_REQ : S_DRAIN;
                    default: state <= S_REQ;
                endcase
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if_instr <= imem_rsp_data;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        pc       <= pc + 64'd4;
                        state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        if_valid    <= 1'b0;
                        instr_count <= instr_count + 1'b1;
                        state       <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rsp_valid) begin
                        state <= S_REQ;
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Directed self-checking bench for fetch_unit (RESET_PC = 0x1000).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [63:0] C_RESET_PC = 64'h1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic [4:0]  OpCode;
    logic [11:0] InstructionP1;
    logic [4:0]  InstructionP2;
    logic        fetch_fault;
    logic [31:0] instr_count;

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit #(.RESET_PC(C_RESET_PC), .CNT_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .OpCode          (OpCode),
        .InstructionP1   (InstructionP1),
        .InstructionP2   (InstructionP2),
        .fetch_fault     (fetch_fault),
        .instr_count     (instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0; stall = 1'b0; redirect_valid = 1'b0;
        redirect_target = 64'h0;
        tick(); tick();
        chk("rst_if_valid", {63'd0, if_valid}, 64'd0);
        chk("rst_if_pc", if_pc, 64'd0);
        chk("rst_if_instr", {32'd0, if_instr}, 64'd0);
        chk("rst_fault", {63'd0, fetch_fault}, 64'd0);
        chk("rst_count", {32'd0, instr_count}, 64'd0);
        chk("rst_opcode", {59'd0, OpCode}, 64'd0);

        // 1: first request, address held while not ready
        rst = 1'b0;
        #1;
        chk("t1_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("t1_addr", imem_addr, 64'h1000);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t1_hold_valid", {63'd0, imem_req_valid}, 64'd1);
            chk("t1_hold_addr", imem_addr, 64'h1000);
        end
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        chk("t1_req_drop", {63'd0, imem_req_valid}, 64'd0);

        // 2: response, fields, consume
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hFFC10113;
        tick(); imem_rsp_valid = 1'b0;
        chk("t2_if_valid", {63'd0, if_valid}, 64'd1);
        chk("t2_if_pc", if_pc, 64'h1000);
        chk("t2_if_instr", {32'd0, if_instr}, 64'hFFC10113);
        chk("t2_opcode", {59'd0, OpCode}, 64'h04);
        chk("t2_p1", {52'd0, InstructionP1}, 64'hFFC);
        chk("t2_p2", {59'd0, InstructionP2}, 64'h02);
        tick();
        chk("t2_consumed", {63'd0, if_valid}, 64'd0);
        chk("t2_count", {32'd0, instr_count}, 64'd1);
        chk("t2_next_req", {63'd0, imem_req_valid}, 64'd1);
        chk("t2_next_addr", imem_addr, 64'h1004);

        // 3: stall in HOLD
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        stall = 1'b1;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00500093;
        tick(); imem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_if_valid", {63'd0, if_valid}, 64'd1);
            chk("t3_if_pc", if_pc, 64'h1004);
            chk("t3_if_instr", {32'd0, if_instr}, 64'h00500093);
            chk("t3_req_valid", {63'd0, imem_req_valid}, 64'd0);
        end
        chk("t3_p1", {52'd0, InstructionP1}, 64'h005);
        chk("t3_p2", {59'd0, InstructionP2}, 64'h01);
        stall = 1'b0; tick();
        chk("t3_release_valid", {63'd0, if_valid}, 64'd0);
        chk("t3_release_count", {32'd0, instr_count}, 64'd2);
        chk("t3_release_req", {63'd0, imem_req_valid}, 64'd1);
        chk("t3_release_addr", imem_addr, 64'h1008);

        // 4: redirect in WAIT, late response is discarded
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 64'h2000;
        tick(); redirect_valid = 1'b0;
        chk("t4_drain_req", {63'd0, imem_req_valid}, 64'd0);
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEADBEEF;
        tick(); imem_rsp_valid = 1'b0;
        chk("t4_if_valid", {63'd0, if_valid}, 64'd0);
        chk("t4_if_instr", {32'd0, if_instr}, 64'h00500093);
        chk("t4_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("t4_addr", imem_addr, 64'h2000);
        chk("t4_count", {32'd0, instr_count}, 64'd2);

        // 5: misaligned redirect, fault is sticky until reset
        redirect_valid = 1'b1; redirect_target = 64'h2002;
        tick();
        chk("t5_fault", {63'd0, fetch_fault}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            redirect_target = 64'h3000;
            redirect_valid = i[0];
            imem_rsp_valid = ~i[0];
            imem_req_ready = 1'b1;
            tick();
            chk("t5_req_valid", {63'd0, imem_req_valid}, 64'd0);
            chk("t5_fault_sticky", {63'd0, fetch_fault}, 64'd1);
        end
        redirect_valid = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b0;
        rst = 1'b1; tick();
        chk("t5_rst_fault", {63'd0, fetch_fault}, 64'd0);
        chk("t5_rst_count", {32'd0, instr_count}, 64'd0);
        rst = 1'b0; #1;
        chk("t5_rst_req", {63'd0, imem_req_valid}, 64'd1);
        chk("t5_rst_addr", imem_addr, 64'h1000);

        // 6: PC wrap, redirect beats consume in HOLD, redirect on accept
        tick();
        redirect_valid = 1'b1; redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick(); redirect_valid = 1'b0;
        chk("t6_addr_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        stall = 1'b1;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00000013;
        tick(); imem_rsp_valid = 1'b0;
        chk("t6_if_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t6_wrap_addr", imem_addr, 64'h0);
        stall = 1'b0; redirect_valid = 1'b1; redirect_target = 64'h2000;
        tick(); redirect_valid = 1'b0;
        chk("t6_no_count", {32'd0, instr_count}, 64'd0);
        chk("t6_if_valid", {63'd0, if_valid}, 64'd0);
        chk("t6_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("t6_addr", imem_addr, 64'h2000);
        imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 64'h3000;
        tick(); imem_req_ready = 1'b0; redirect_valid = 1'b0;
        chk("t6_accept_drain", {63'd0, imem_req_valid}, 64'd0);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h12345678;
        tick(); imem_rsp_valid = 1'b0;
        chk("t6_drain_valid", {63'd0, if_valid}, 64'd0);
        chk("t6_drain_req", {63'd0, imem_req_valid}, 64'd1);
        chk("t6_drain_addr", imem_addr, 64'h3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
